// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU-side RAM plus LED/switch memory-mapped I/O with sticky bus-error capture.
// Switches pass a two-flop synchroniser and a stability counter before becoming readable.
module mem_io_ctrl #(
    parameter int         RAM_WORDS       = 256,
    parameter logic [8:0] LED_ADDR        = 9'h100,
    parameter logic [8:0] SW_ADDR         = 9'h140,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    input  logic [7:0]  SW,
    output logic [7:0]  LEDR,
    output logic        bus_err,
    output logic [8:0]  err_addr
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int AW = $clog2(RAM_WORDS);

    logic [15:0]   ram [RAM_WORDS];
    logic [7:0]    sw_s1, sw_s2, sw_cand, sw_stable;
    logic [CW-1:0] cnt;
    logic          is_rd, is_wr, in_ram, is_led, is_sw, err;
    logic [15:0]   rd_src;

    always_comb begin
        is_rd  = mem_cmd == 2'b01;
        is_wr  = mem_cmd == 2'b10;
        in_ram = {23'd0, mem_addr} < 32'(RAM_WORDS);
        is_led = mem_addr == LED_ADDR;
        is_sw  = mem_addr == SW_ADDR;
        err    = mem_cmd == 2'b11 || ((is_rd || is_wr) && !(in_ram || is_led || is_sw)) || (is_wr && is_sw);
        rd_src = in_ram ? ram[mem_addr[AW-1:0]] : is_led ? {8'h00, LEDR} : is_sw ? {8'h00, sw_stable} : 16'h0000;
    end

    // RAM has no reset so its contents survive; a write edge seen under reset is dropped.
    always_ff @(posedge clk)
        if (reset && is_wr && in_ram)
            ram[mem_addr[AW-1:0]] <= write_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            LEDR      <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            sw_cand   <= '0;
            sw_stable <= '0;
            cnt       <= '0;
        end else begin
            if (is_rd)
                read_data <= rd_src;
            if (is_wr && is_led)
                LEDR <= write_data[7:0];
            if (err && !bus_err) begin
                bus_err  <= 1'b1;
                err_addr <= mem_addr;
            end
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            if (sw_s2 != sw_cand) begin
                sw_cand <= sw_s2;
                cnt     <= '0;
            end else if (cnt < CW'(DEBOUNCE_CYCLES - 1))
                cnt <= cnt + CW'(1);
            else
                sw_stable <= sw_cand;
        end
    end
endmodule
